// File: rtl/ahbl_apb_bridge_if.sv
// Bus interfaces for the AHB-Lite to APB3 bridge.
// ahbl_if carries one AHB-Lite slave port, apb_if one APB3 port.
`timescale 1ns/1ps

interface ahbl_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    // Master side: the AHB master plus the interconnect that produces HREADY
    modport master (
        output HSEL, HADDR, HWRITE, HTRANS, HSIZE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    // Slave side: the bridge
    modport slave (
        input  HSEL, HADDR, HWRITE, HTRANS, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

interface apb_if #(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] PADDR;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [31:0]       PWDATA;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    // Master side: the bridge
    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    // Slave side: an APB peripheral
    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/ahbl_apb_bridge.sv
// AHB-Lite slave to APB3 master bridge.
// Every accepted AHB transfer becomes one 32-bit APB access
// (SETUP, then ACCESS until PREADY). PSLVERR or an ACCESS phase that
// stalls for TIMEOUT cycles is returned as a two-cycle AHB ERROR.
`timescale 1ns/1ps

module ahbl_apb_bridge #(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 16   // 0 disables the ACCESS timeout
) (
    input  logic   HCLK,
    input  logic   HRESETN,
    ahbl_if.slave  ahb,
    apb_if.master  apb
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE,
        ERR1,
        ERR2
    } state_t;

    // Counter wide enough to hold TIMEOUT; with the timeout disabled it
    // just saturates at all-ones and is never compared.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX =
        (TIMEOUT > 0) ? CNT_W'(TIMEOUT) : {CNT_W{1'b1}};

    state_t            r_state;
    logic              r_hreadyout;
    logic              r_hresp;
    logic [31:0]       r_hrdata;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_sample;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_timeout;
    logic              w_unused;

    // A valid address phase: selected, bus ready, NONSEQ or SEQ
    assign w_sample = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];

    // Saturating increment; the timeout fires on the edge at which the
    // count would reach TIMEOUT, so exactly TIMEOUT ACCESS cycles occur.
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_timeout = (TIMEOUT != 0) && (w_cnt_inc == CNT_MAX);

    // HSIZE is ignored (word accesses only), upper address bits and the
    // SEQ/NONSEQ distinction do not reach APB.
    assign w_unused = ^{ahb.HSIZE, ahb.HADDR[31:ADDR_W], ahb.HTRANS[0]};

    // Transfer FSM with all bus outputs registered alongside the state
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            r_state     <= IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_hrdata    <= 32'h0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                // States in which the AHB side is ready and may accept
                IDLE, DONE, ERR2: begin
                    if (w_sample) begin
                        r_state     <= SETUP;
                        r_paddr     <= ahb.HADDR[ADDR_W-1:0];
                        r_pwrite    <= ahb.HWRITE;
                        r_hreadyout <= 1'b0;
                        r_hresp     <= 1'b0;
                        r_psel      <= 1'b1;
                        r_penable   <= 1'b0;
                    end else begin
                        r_state     <= IDLE;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= 1'b0;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                    end
                end

                SETUP: begin
                    r_state   <= ACCESS;
                    r_penable <= 1'b1;
                    r_cnt     <= '0;
                end

                // PREADY is checked before the timeout so a completion on
                // the last permitted cycle is treated as normal.
                ACCESS: begin
                    if (apb.PREADY) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        if (apb.PSLVERR) begin
                            r_state     <= ERR1;
                            r_hreadyout <= 1'b0;
                            r_hresp     <= 1'b1;
                        end else begin
                            r_state     <= DONE;
                            r_hreadyout <= 1'b1;
                            r_hresp     <= 1'b0;
                            if (!r_pwrite) begin
                                r_hrdata <= apb.PRDATA;
                            end
                        end
                    end else if (w_timeout) begin
                        r_state     <= ERR1;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_hreadyout <= 1'b0;
                        r_hresp     <= 1'b1;
                        r_cnt       <= w_cnt_inc;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                // First ERROR cycle: HREADYOUT low, second: high
                ERR1: begin
                    r_state     <= ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b1;
                end

                default: begin
                    r_state     <= IDLE;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b0;
                    r_psel      <= 1'b0;
                    r_penable   <= 1'b0;
                end
            endcase
        end
    end

    assign ahb.HRDATA    = r_hrdata;
    assign ahb.HREADYOUT = r_hreadyout;
    assign ahb.HRESP     = r_hresp;

    assign apb.PADDR   = r_paddr;
    assign apb.PSEL    = r_psel;
    assign apb.PENABLE = r_penable;
    assign apb.PWRITE  = r_pwrite;
    // Write data is passed straight through; the AHB master holds HWDATA
    // for the whole data phase, which spans SETUP and ACCESS.
    assign apb.PWDATA  = (r_psel && r_pwrite) ? ahb.HWDATA : 32'h0;

endmodule

// File: tb/tb_ahbl_apb_bridge.sv
// Testbench for ahbl_apb_bridge: directed AHB transfers against a
// transfer-level model of the expected bus behaviour, compared each cycle.
`timescale 1ns/1ps

module tb_ahbl_apb_bridge;
    localparam int ADDR_W = 12;
    localparam int TO     = 16;

    logic HCLK    = 1'b0;
    logic HRESETN = 1'b0;

    always #5 HCLK = ~HCLK;

    ahbl_if ahb ();
    apb_if #(.ADDR_W(ADDR_W)) apb ();

    // Single-slave system: the bus HREADY is this slave's HREADYOUT
    assign ahb.HREADY = ahb.HREADYOUT;

    ahbl_apb_bridge #(.ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
        .HCLK    (HCLK),
        .HRESETN (HRESETN),
        .ahb     (ahb),
        .apb     (apb)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Expected outputs for the current cycle
    bit                chk_en = 1'b0;
    logic              e_hro, e_hresp, e_psel, e_pen, e_pwrite;
    logic [ADDR_W-1:0] e_paddr;
    logic [31:0]       e_pwdata, e_hrdata;

    // Run-length trackers for literal latency checks
    int lo_cnt = 0, lo_run = 0, acc_cnt = 0, acc_run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_exp(input logic hro, input logic hresp, input logic psel, input logic pen);
        e_hro    = hro;
        e_hresp  = hresp;
        e_psel   = psel;
        e_pen    = pen;
        e_pwdata = (psel && e_pwrite) ? ahb.HWDATA : 32'h0;
    endtask

    task automatic model_reset();
        e_paddr  = '0;
        e_pwrite = 1'b0;
        e_hrdata = 32'h0;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Compare process: every falling edge, all outputs against the model
    always @(negedge HCLK) begin
        if (chk_en) begin
            check("HREADYOUT", 32'(ahb.HREADYOUT), 32'(e_hro));
            check("HRESP",     32'(ahb.HRESP),     32'(e_hresp));
            check("HRDATA",    ahb.HRDATA,         e_hrdata);
            check("PSEL",      32'(apb.PSEL),      32'(e_psel));
            check("PENABLE",   32'(apb.PENABLE),   32'(e_pen));
            check("PADDR",     32'(apb.PADDR),     32'(e_paddr));
            check("PWRITE",    32'(apb.PWRITE),    32'(e_pwrite));
            check("PWDATA",    apb.PWDATA,         e_pwdata);
        end
        if (!HRESETN) begin
            lo_cnt  = 0;
            acc_cnt = 0;
        end else begin
            if (!ahb.HREADYOUT) lo_cnt++;
            else if (lo_cnt != 0) begin lo_run = lo_cnt; lo_cnt = 0; end
            if (apb.PENABLE) acc_cnt++;
            else if (acc_cnt != 0) begin acc_run = acc_cnt; acc_cnt = 0; end
        end
    end

    // Non-transfer cycles: each gets a zero-wait OKAY and leaves APB idle
    task automatic idle(input int n, input logic hsel, input logic [1:0] htrans);
        for (int i = 0; i < n; i++) begin
            ahb.HSEL   = hsel;
            ahb.HTRANS = htrans;
            ahb.HADDR  = $urandom;
            ahb.HWRITE = 1'b1;
            step();
            set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // One AHB transfer. Called in a cycle where the bridge is ready; the
    // address phase is driven in that cycle. Returns in the first cycle
    // in which HREADYOUT is high again (DONE or second ERROR cycle).
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int nwait, input bit err);
        bit tmo;
        bit last;
        int nacc;
        lo_run  = 0;
        acc_run = 0;
        ahb.HSEL   = 1'b1;
        ahb.HTRANS = 2'b10;
        ahb.HADDR  = addr;
        ahb.HWRITE = wr;
        ahb.HSIZE  = 3'b010;
        step();
        // SETUP: PREADY/PSLVERR driven high to show they are ignored here
        ahb.HSEL    = 1'b0;
        ahb.HTRANS  = 2'b00;
        ahb.HWDATA  = wdata;
        apb.PREADY  = 1'b1;
        apb.PSLVERR = 1'b1;
        apb.PRDATA  = 32'hBAD0BAD0;
        e_paddr  = addr[ADDR_W-1:0];
        e_pwrite = wr;
        set_exp(1'b0, 1'b0, 1'b1, 1'b0);
        step();
        tmo  = (TO > 0) && (nwait >= TO);
        nacc = tmo ? TO : nwait + 1;
        for (int i = 0; i < nacc; i++) begin
            last        = !tmo && (i == nacc - 1);
            apb.PREADY  = last;
            apb.PSLVERR = last ? err : 1'b1;
            apb.PRDATA  = last ? rdata : 32'hBAD0BAD0;
            set_exp(1'b0, 1'b0, 1'b1, 1'b1);
            step();
        end
        apb.PREADY  = 1'b1;
        apb.PSLVERR = 1'b0;
        apb.PRDATA  = 32'hBAD0BAD0;
        if (tmo || err) begin
            set_exp(1'b0, 1'b1, 1'b0, 1'b0);
            step();
            set_exp(1'b1, 1'b1, 1'b0, 1'b0);
        end else begin
            if (!wr) e_hrdata = rdata;
            set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        ahb.HSEL    = 1'b0;
        ahb.HADDR   = 32'h0;
        ahb.HWRITE  = 1'b0;
        ahb.HTRANS  = 2'b00;
        ahb.HSIZE   = 3'b010;
        ahb.HWDATA  = 32'h0;
        apb.PRDATA  = 32'h0;
        apb.PREADY  = 1'b1;
        apb.PSLVERR = 1'b0;
        model_reset();
        chk_en = 1'b1;

        // Reset values
        step();
        step();
        check("reset_HREADYOUT", 32'(ahb.HREADYOUT), 32'h1);
        HRESETN = 1'b1;
        idle(2, 1'b0, 2'b00);

        // Write 0xDEADBEEF to 0x004, zero-wait slave
        xfer(1'b1, 32'h0000_0004, 32'hDEADBEEF, 32'h0, 0, 1'b0);
        idle(1, 1'b0, 2'b00);
        check("wr_latency", lo_run, 2);
        check("wr_paddr", 32'(apb.PADDR), 32'h004);
        check("wr_pwrite", 32'(apb.PWRITE), 32'h1);

        // Read 0x010, three wait states
        xfer(1'b0, 32'h0000_0010, 32'h5555_AAAA, 32'h12345678, 3, 1'b0);
        idle(1, 1'b0, 2'b00);
        check("rd_latency", lo_run, 5);
        check("rd_hrdata", ahb.HRDATA, 32'h12345678);

        // Write answered with PSLVERR
        xfer(1'b1, 32'h0000_000C, 32'hCAFEF00D, 32'h0, 1, 1'b1);
        idle(1, 1'b0, 2'b00);
        check("slverr_latency", lo_run, 4);
        check("slverr_hrdata_kept", ahb.HRDATA, 32'h12345678);

        // PREADY never arrives: timeout
        xfer(1'b1, 32'h0000_0040, 32'h0BAD_CAFE, 32'h0, 100, 1'b0);
        idle(1, 1'b1, 2'b00);
        check("tmo_access_cycles", acc_run, 16);
        check("tmo_latency", lo_run, 18);

        // PREADY on the last permitted ACCESS cycle completes normally
        xfer(1'b0, 32'hABCD_E7FC, 32'h0, 32'hA5A5_0F0F, TO - 1, 1'b0);
        idle(1, 1'b0, 2'b10);
        check("edge_access_cycles", acc_run, 16);
        check("edge_hrdata", ahb.HRDATA, 32'hA5A5_0F0F);
        check("edge_paddr", 32'(apb.PADDR), 32'h7FC);

        // Back-to-back read then write, then again with IDLE/BUSY between
        xfer(1'b0, 32'h0000_0000, 32'h0, 32'h1111_2222, 0, 1'b0);
        xfer(1'b1, 32'h0000_0008, 32'h3333_4444, 32'h0, 0, 1'b0);
        idle(1, 1'b1, 2'b01);
        idle(1, 1'b1, 2'b00);
        idle(1, 1'b0, 2'b11);
        xfer(1'b0, 32'h0000_0000, 32'h0, 32'h7777_8888, 1, 1'b0);
        xfer(1'b1, 32'h0000_0008, 32'h9999_AAAA, 32'h0, 2, 1'b0);

        // Read error then immediate next transfer from the ERROR response
        xfer(1'b0, 32'h0000_0020, 32'h0, 32'hDEAD_0000, 0, 1'b1);
        xfer(1'b0, 32'h0000_0024, 32'h0, 32'h0000_BEEF, 0, 1'b0);
        idle(2, 1'b0, 2'b00);

        // Asynchronous reset during ACCESS
        ahb.HSEL   = 1'b1;
        ahb.HTRANS = 2'b10;
        ahb.HADDR  = 32'h0000_0030;
        ahb.HWRITE = 1'b0;
        step();
        ahb.HSEL   = 1'b0;
        ahb.HTRANS = 2'b00;
        apb.PREADY = 1'b0;
        e_paddr  = 12'h030;
        e_pwrite = 1'b0;
        set_exp(1'b0, 1'b0, 1'b1, 1'b0);
        step();
        set_exp(1'b0, 1'b0, 1'b1, 1'b1);
        #2;
        HRESETN = 1'b0;
        #1;
        check("arst_psel", 32'(apb.PSEL), 32'h0);
        check("arst_penable", 32'(apb.PENABLE), 32'h0);
        check("arst_no_edge", 32'(HCLK), 32'h1);
        model_reset();
        step();
        step();
        apb.PREADY = 1'b1;
        HRESETN = 1'b1;
        idle(1, 1'b0, 2'b00);
        xfer(1'b0, 32'h0000_0034, 32'h0, 32'h0C0F_FEE0, 1, 1'b0);
        idle(1, 1'b0, 2'b00);
        check("post_rst_latency", lo_run, 3);
        check("post_rst_hrdata", ahb.HRDATA, 32'h0C0F_FEE0);
        idle(2, 1'b0, 2'b00);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
